// File: rtl/snake_pkg.sv
// Shared types for the snake movement engine: direction codes, FSM states,
// death causes and the direction-reversal helper.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SCAN,
    ST_COMMIT,
    ST_DEAD
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_WALL = 2'b01,
    CAUSE_SELF = 2'b10
  } cause_e;

  // Direction that would reverse the snake onto its own neck.
  function automatic dir_e opposite(input dir_e d);
    dir_e r;
    r = DIR_LEFT;
    case (d)
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      default:   r = DIR_LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Candidate head cell for one move on a WIDTH x HEIGHT grid (index = y*WIDTH + x).
// Ports: head (current head cell), dir (move direction),
//        cand (candidate cell), wall (move leaves the grid).
// Optional macro SNAKE_WRAP_EN: edges wrap to the opposite side; wall stays 0.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned HEIGHT = 24,
  parameter int unsigned POS_W  = 10
) (
  input  logic [POS_W-1:0] head,
  input  dir_e             dir,
  output logic [POS_W-1:0] cand,
  output logic             wall
);

  localparam int unsigned COL_SPAN = WIDTH * (HEIGHT - 1);

  int unsigned h;
  int unsigned x;
  int unsigned y;
  int unsigned nxt;

  always_comb begin
    h    = 32'(head);
    x    = h % WIDTH;
    y    = h / WIDTH;
    nxt  = h;
    wall = 1'b0;
    case (dir)
      DIR_LEFT: begin
        if (x == 0) begin
`ifdef SNAKE_WRAP_EN
          nxt = h + (WIDTH - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nxt = h - 1;
        end
      end
      DIR_RIGHT: begin
        if (x == WIDTH - 1) begin
`ifdef SNAKE_WRAP_EN
          nxt = h - (WIDTH - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nxt = h + 1;
        end
      end
      DIR_UP: begin
        if (y == 0) begin
`ifdef SNAKE_WRAP_EN
          nxt = h + COL_SPAN;
`else
          wall = 1'b1;
`endif
        end else begin
          nxt = h - WIDTH;
        end
      end
      default: begin
        if (y == HEIGHT - 1) begin
`ifdef SNAKE_WRAP_EN
          nxt = h - COL_SPAN;
`else
          wall = 1'b1;
`endif
        end else begin
          nxt = h + WIDTH;
        end
      end
    endcase
    cand = POS_W'(nxt);
  end

endmodule

// File: rtl/snake_engine.sv
// Multi-cycle snake movement engine. Each accepted step computes a candidate
// head, checks the grid edge, scans the body one segment per clock for a
// self hit, then shifts the body in a single commit edge.
// Ports: clk, rst_n (async active-low), step/di (move request + direction),
//        grow (pulse, sets grow-pending), body (flattened segments, 0 = head),
//        head, len, ready (idle and alive), done (pulse after commit),
//        dead (sticky), dead_cause (00 none, 01 wall, 10 self).
// Optional macro SNAKE_WRAP_EN: grid edges wrap instead of killing the snake.
module snake_engine
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HEIGHT    = 24,
  parameter int unsigned POS_W     = 10,
  parameter int unsigned LEN_W     = 5,
  parameter int unsigned START_POS = 100,
  parameter int unsigned START_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step,
  input  logic [1:0]               di,
  input  logic                     grow,
  output logic [MAX_LEN*POS_W-1:0] body,
  output logic [POS_W-1:0]         head,
  output logic [LEN_W-1:0]         len,
  output logic                     ready,
  output logic                     done,
  output logic                     dead,
  output logic [1:0]               dead_cause
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_e           state;
  dir_e             cur_dir;
  dir_e             mv_dir;
  logic [POS_W-1:0] seg [MAX_LEN];
  logic [POS_W-1:0] cand_q;
  logic [POS_W-1:0] cand;
  logic             wall;
  logic             grow_pend;
  logic             grow_apply;
  logic             grow_ok_c;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;

  snake_next_head #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .POS_W (POS_W)
  ) u_next_head (
    .head(seg[0]),
    .dir (mv_dir),
    .cand(cand),
    .wall(wall)
  );

  // Growth only applies while there is room for another segment.
  assign grow_ok_c = grow_pend && (len < LEN_W'(MAX_LEN));

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_body
    assign body[g*POS_W +: POS_W] = seg[g];
  end

  assign head = seg[0];

  // Move FSM: IDLE -> CALC -> SCAN -> COMMIT -> IDLE, DEAD is terminal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cur_dir <= DIR_RIGHT;
      mv_dir  <= DIR_RIGHT;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg[i] <= (i < START_LEN) ? POS_W'(START_POS - i) : '0;
      end
      len        <= LEN_W'(START_LEN);
      cand_q     <= '0;
      idx        <= '0;
      last_idx   <= '0;
      grow_pend  <= 1'b0;
      grow_apply <= 1'b0;
      ready      <= 1'b1;
      done       <= 1'b0;
      dead       <= 1'b0;
      dead_cause <= CAUSE_NONE;
    end else begin
      done <= 1'b0;
      if (grow && state != ST_DEAD) begin
        grow_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (step) begin
            // A 180-degree reversal keeps the current heading.
            mv_dir <= (dir_e'(di) == opposite(cur_dir)) ? cur_dir : dir_e'(di);
            ready  <= 1'b0;
            state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          cand_q     <= cand;
          grow_apply <= grow_ok_c;
          idx        <= '0;
          // Last scanned index: the tail vacates unless the snake grows.
          last_idx   <= grow_ok_c ? IDX_W'(len - LEN_W'(1)) : IDX_W'(len - LEN_W'(2));
          if (wall) begin
            dead       <= 1'b1;
            dead_cause <= CAUSE_WALL;
            state      <= ST_DEAD;
          end else begin
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (seg[idx] == cand_q) begin
            dead       <= 1'b1;
            dead_cause <= CAUSE_SELF;
            state      <= ST_DEAD;
          end else if (idx == last_idx) begin
            state <= ST_COMMIT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_COMMIT: begin
          for (int unsigned i = 1; i < MAX_LEN; i++) begin
            seg[i] <= seg[i-1];
          end
          seg[0] <= cand_q;
          if (grow_apply) begin
            len <= len + LEN_W'(1);
          end
          // A grow arriving in this very cycle survives for the next move.
          grow_pend <= grow;
          cur_dir   <= mv_dir;
          ready     <= 1'b1;
          done      <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_DEAD: begin
          state <= ST_DEAD;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised, multi-cycle snake movement engine for the VGA snake game. Once per game tick it advances the snake one cell. It rejects 180° reversals, applies pending growth, and detects wall and self-collision by scanning the body one segment per clock. It sits between the tick generator / keyboard direction latch and the frame renderer, which reads the flattened body vector.

## Interface
- `MAX_LEN`, 16: body capacity in segments.
- `WIDTH`, 32: grid columns.
- `HEIGHT`, 24: grid rows.
- `POS_W`, 10: cell index width; index = y*WIDTH + x.
- `LEN_W`, 5: length counter width; must hold MAX_LEN.
- `START_POS`, 100: head cell after reset; requires START_POS%WIDTH ≥ START_LEN-1.
- `START_LEN`, 3: length after reset, 2..MAX_LEN.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `step`  in  1  move request; accepted only while `ready`=1.
- `di`  in  2  requested direction, sampled with `step`: 00 left, 01 right, 10 up, 11 down.
- `grow`  in  1  single-cycle pulse; sets the grow-pending flag.
- `body`  out  MAX_LEN*POS_W  segment i at [i*POS_W +: POS_W]; segment 0 is the head; segments ≥ `len` are don't-care.
- `head`  out  POS_W  equals segment 0.
- `len`  out  LEN_W  current length.
- `ready`  out  1  idle and alive.
- `done`  out  1  one-cycle pulse after a committed move.
- `dead`  out  1  sticky; cleared only by reset.
- `dead_cause`  out  2  00 none, 01 wall, 10 self.

## Operation
- Reset values:
  - state IDLE; current direction right.
  - segment i = START_POS - i for i < START_LEN; `len`=START_LEN.
  - `ready`=1; `done`=0; `dead`=0; `dead_cause`=00; grow-pending cleared.
- States: IDLE → CALC → SCAN → COMMIT → IDLE. CALC → DEAD on a wall hit; SCAN → DEAD on a self hit.
- IDLE:
  - `step` with `ready` latches `di`.
  - If `di` is the opposite of the current direction, the current direction is kept.
- CALC:
  - Registers the candidate head.
  - Left is illegal at x=0, right at x=WIDTH-1, up at y=0, down at y=HEIGHT-1.
  - An illegal move goes to DEAD with cause 01.
- SCAN:
  - Scan length n = `len` if growth applies, else `len`-1. The tail cell vacates, so moving onto it is legal.
  - Growth applies when grow-pending=1 and `len` < MAX_LEN.
  - Index k runs 0..n-1, one compare per cycle.
  - A match with segment k goes to DEAD with cause 10. The compare runs in the same cycle; no further indices are scanned.
- COMMIT:
  - Segment i takes segment i-1 for i ≥ 1; segment 0 takes the candidate.
  - If growth applies, `len`+1.
  - grow-pending clears; it also clears when `len`=MAX_LEN, where length saturates and the tail moves normally.
  - Current direction is updated.
- DEAD: `body` and `len` are frozen; `ready`=0; `step` and `grow` are ignored.
- `grow` may arrive in any state. A `grow` in the COMMIT cycle wins over the clear and stays pending for the next move.
- `step` while `ready`=0 is dropped; nothing is queued.
- Reset asserted mid-move restores reset values immediately; a partial shift is never visible.

## Timing
- `step` is sampled at edge T.
- CALC completes at T+1; scan edges run T+2..T+1+n; commit happens at T+2+n.
- `done`=1 and `ready`=1 in the cycle after the commit edge. `ready` is low from the cycle after T.
- Move latency is n+2 cycles: 4 cycles for `len`=3 without growth.
- A wall death is visible after T+1; a self death is visible the cycle after the matching scan edge.
- `body`, `head` and `len` change only at the commit edge. The renderer may read them at any time.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Edges wrap: x=WIDTH-1 moving right becomes x=0 on the same row, and symmetrically for the other edges.
  - Cause 01 is never produced.
- Undefined: edge moves are deaths, as described in Operation.

## Structure
- Package `snake_pkg` holds:
  - direction codes DIR_LEFT/RIGHT/UP/DOWN;
  - the `opposite()` function;
  - the FSM state enum;
  - dead-cause codes.
- Sub-module `snake_next_head`: combinational; takes head, direction, WIDTH and HEIGHT and outputs the candidate cell plus a wall flag. It contains the wrap logic under `SNAKE_WRAP_EN`.

## Test plan
- Reset release → `head`=100, segments 100,99,98, `len`=3, `ready`=1. Then `step` with `di`=01 → `done` 4 cycles later; segments 101,100,99.
- Heading right, `step` with `di`=00 → reversal ignored; head 101→102.
- `grow` pulse, then `step` with `di`=01 → `len`=4, segments 103,102,101,100, `done` 5 cycles after the step. At `len`=MAX_LEN, `grow`+`step` → `len` unchanged.
- Drive the head to x=31, then `step` right → `dead`=1, `dead_cause`=01, `body` frozen. With `SNAKE_WRAP_EN` → head at x=0 on the same row.
- START_LEN=5 instance, moves down, left, up → head candidate 99 hits segment 3 → `dead`=1, `dead_cause`=10. A move onto the vacating tail cell stays alive.
- `step` pulsed during SCAN → ignored; `rst_n` low mid-SCAN → reset values within the same cycle.
